// File: rtl/alu_ctrl_pkg.sv
// Shared constants and select-line encoding for the ALU mode controller.
package alu_ctrl_pkg;

    localparam int NUM_OPS = 7;
    localparam int IDX_W   = 3;
    localparam int SEL_W   = NUM_OPS - 1;

    // Index 0 selects the default ALU operation, so it maps to an all-zero select.
    function automatic logic [SEL_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int k = 1; k < NUM_OPS; k++) begin
            if (idx == IDX_W'(k)) sel[k-1] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/alu_mode_controller_btn_debounce.sv
// Two-flop synchronizer, stable-level debouncer and rising-edge press pulse for one raw button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic [1:0]    valid_q;
    logic          armed;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Presses are only honoured once the button has been seen released after reset,
    // so a button held through reset cannot produce a step on release of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= '0;
            valid_q <= '0;
            armed   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            valid_q <= {valid_q[0], 1'b1};
            if (valid_q[1] && !sync_q[1]) armed <= 1'b1;
            if (sync_q[1] != level) begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(DEBOUNCE_CYCLES - 2)) level <= sync_q[1];
            end else begin
                cnt <= '0;
            end
            level_q <= level;
            pulse   <= armed & level & ~level_q;
        end
    end

endmodule

// File: rtl/alu_mode_controller.sv
// Operation sequencer for the ALU display datapath: button/auto-scan stepping,
// operand latch and registered one-hot select.
module alu_mode_controller
    import alu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_CYCLES     = 50000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             auto_en,
    input  logic             load,
    input  logic [9:0]       operands_in,
    output logic [9:0]       operands_out,
    output logic [SEL_W-1:0] sw_sel,
    output logic [IDX_W-1:0] op_index,
    output logic             update
);

    localparam int               SCW      = $clog2(SCAN_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    logic             next_pulse;
    logic             prev_pulse;
    logic             load_pulse;
    logic [1:0]       auto_q;
    logic             auto_sync;
    logic [SCW-1:0]   scan_cnt;
    logic             scan_tc;
    logic             manual;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;
    logic [IDX_W-1:0] idx_nxt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .resetn(resetn), .raw(btn_next), .pulse(next_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk(clk), .resetn(resetn), .raw(btn_prev), .pulse(prev_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .resetn(resetn), .raw(load), .pulse(load_pulse)
    );

    assign auto_sync = auto_q[1];

    // Simultaneous next and prev cancel out, and also suppress the auto step that cycle.
    always_comb begin
        idx_inc = (op_index == LAST_IDX) ? '0 : op_index + 1'b1;
        idx_dec = (op_index == '0) ? LAST_IDX : op_index - 1'b1;
        manual  = next_pulse | prev_pulse;
        scan_tc = auto_sync && (scan_cnt == SCW'(SCAN_CYCLES - 1));
        idx_nxt = op_index;
        if (next_pulse && !prev_pulse)      idx_nxt = idx_inc;
        else if (prev_pulse && !next_pulse) idx_nxt = idx_dec;
        else if (!manual && scan_tc)        idx_nxt = idx_inc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            auto_q       <= '0;
            scan_cnt     <= '0;
            op_index     <= '0;
            sw_sel       <= '0;
            operands_out <= '0;
            update       <= 1'b0;
        end else begin
            auto_q <= {auto_q[0], auto_en};
            if (!auto_sync || manual || scan_tc) scan_cnt <= '0;
            else                                 scan_cnt <= scan_cnt + 1'b1;
            op_index <= idx_nxt;
            sw_sel   <= idx_to_onehot(idx_nxt);
            if (load_pulse) operands_out <= operands_in;
            update <= (idx_nxt != op_index) | load_pulse;
        end
    end

endmodule

// File: tb/tb_alu_mode_controller.sv
// Directed-vector bench for alu_mode_controller with short debounce and scan periods.
module tb_alu_mode_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic       load = 1'b0;
    logic [9:0] operands_in = '0;
    logic [9:0] operands_out;
    logic [5:0] sw_sel;
    logic [2:0] op_index;
    logic       update;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mode_controller #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(10)) dut (
        .clk(clk), .resetn(resetn), .btn_next(btn_next), .btn_prev(btn_prev),
        .auto_en(auto_en), .load(load), .operands_in(operands_in),
        .operands_out(operands_out), .sw_sel(sw_sel), .op_index(op_index), .update(update)
    );

    always #5 clk = ~clk;

    // mask bits: [0] next, [1] prev, [2] load; counts update pulses over hold + release.
    task automatic press_btn(input logic [2:0] mask, input int hold, output int upd);
        upd = 0;
        btn_next = mask[0];
        btn_prev = mask[1];
        load     = mask[2];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (update === 1'b1) upd++;
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        load     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (update === 1'b1) upd++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (op_index !== 3'd0) begin n_fail++; $display("FAIL reset_op_index: got %0d expected 0", op_index); end
        n_checks++; if (sw_sel !== 6'd0) begin n_fail++; $display("FAIL reset_sw_sel: got %b expected 000000", sw_sel); end
        n_checks++; if (operands_out !== 10'd0) begin n_fail++; $display("FAIL reset_operands: got %h expected 000", operands_out); end
        n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b expected 0", update); end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (op_index !== 3'd0 || update !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got idx=%0d upd=%b expected idx=0 upd=0", op_index, update);
        end
    endtask

    task automatic test_next_latency();
        int exp_idx;
        btn_next = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_idx = (i >= 7) ? 1 : 0;
            n_checks++; if (op_index !== 3'(exp_idx)) begin
                n_fail++; $display("FAIL next_latency_idx edge %0d: got %0d expected %0d", i, op_index, exp_idx);
            end
            n_checks++; if (update !== 1'(i == 7)) begin
                n_fail++; $display("FAIL next_latency_update edge %0d: got %b expected %b", i, update, i == 7);
            end
            if (i == 7) begin
                n_checks++; if (sw_sel !== 6'b000001) begin n_fail++; $display("FAIL next_sw_sel: got %b expected 000001", sw_sel); end
            end
        end
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (op_index !== 3'd1) begin n_fail++; $display("FAIL next_release_idx: got %0d expected 1", op_index); end
    endtask

    task automatic test_prev_wrap();
        int upd;
        press_btn(3'b010, 12, upd);
        n_checks++; if (op_index !== 3'd0 || upd != 1) begin
            n_fail++; $display("FAIL prev_1_to_0: got idx=%0d pulses=%0d expected idx=0 pulses=1", op_index, upd);
        end
        press_btn(3'b010, 12, upd);
        n_checks++; if (op_index !== 3'd6 || upd != 1) begin
            n_fail++; $display("FAIL prev_wrap: got idx=%0d pulses=%0d expected idx=6 pulses=1", op_index, upd);
        end
        n_checks++; if (sw_sel !== 6'b100000) begin n_fail++; $display("FAIL prev_wrap_sel: got %b expected 100000", sw_sel); end
        press_btn(3'b001, 12, upd);
        n_checks++; if (op_index !== 3'd0 || upd != 1) begin
            n_fail++; $display("FAIL next_wrap: got idx=%0d pulses=%0d expected idx=0 pulses=1", op_index, upd);
        end
        n_checks++; if (sw_sel !== 6'b000000) begin n_fail++; $display("FAIL next_wrap_sel: got %b expected 000000", sw_sel); end
    endtask

    task automatic test_bounce();
        int upd;
        upd = 0;
        for (int i = 0; i < 12; i++) begin
            btn_next = ((i / 2) % 2 == 0);
            @(negedge clk);
            if (update === 1'b1) upd++;
        end
        btn_next = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (update === 1'b1) upd++;
        end
        n_checks++; if (op_index !== 3'd0 || upd != 0) begin
            n_fail++; $display("FAIL bounce: got idx=%0d pulses=%0d expected idx=0 pulses=0", op_index, upd);
        end
    endtask

    task automatic test_auto_scan();
        int  exp_idx;
        logic exp_upd;
        auto_en = 1'b1;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (i < 82)       exp_idx = (i >= 12) ? ((i - 12) / 10 + 1) % 7 : 0;
            else if (i < 89)  exp_idx = 1;
            else if (i < 99)  exp_idx = 2;
            else if (i < 109) exp_idx = 3;
            else              exp_idx = 4;
            exp_upd = (i >= 12 && i <= 72 && (i - 12) % 10 == 0) || i == 82 || i == 89 || i == 99 || i == 109;
            n_checks++; if (op_index !== 3'(exp_idx)) begin
                n_fail++; $display("FAIL auto_idx edge %0d: got %0d expected %0d", i, op_index, exp_idx);
            end
            n_checks++; if (update !== exp_upd) begin
                n_fail++; $display("FAIL auto_update edge %0d: got %b expected %b", i, update, exp_upd);
            end
            if (i == 82) btn_next = 1'b1;
            if (i == 95) btn_next = 1'b0;
        end
        auto_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_checks++; if (op_index !== 3'd4 || update !== 1'b0) begin
                n_fail++; $display("FAIL auto_off cycle %0d: got idx=%0d upd=%b expected idx=4 upd=0", i, op_index, update);
            end
        end
    endtask

    task automatic test_load();
        int upd;
        operands_in = 10'h2A5;
        load = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_checks++; if (operands_out !== ((i >= 7) ? 10'h2A5 : 10'h000)) begin
                n_fail++; $display("FAIL load_operands edge %0d: got %h expected %h", i, operands_out, (i >= 7) ? 10'h2A5 : 10'h000);
            end
            n_checks++; if (update !== 1'(i == 7)) begin
                n_fail++; $display("FAIL load_update edge %0d: got %b expected %b", i, update, i == 7);
            end
        end
        load = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (op_index !== 3'd4) begin n_fail++; $display("FAIL load_idx_kept: got %0d expected 4", op_index); end
        press_btn(3'b100, 12, upd);
        n_checks++; if (operands_out !== 10'h2A5 || upd != 1) begin
            n_fail++; $display("FAIL load_same_value: got %h pulses=%0d expected 2a5 pulses=1", operands_out, upd);
        end
        press_btn(3'b011, 12, upd);
        n_checks++; if (op_index !== 3'd4 || upd != 0) begin
            n_fail++; $display("FAIL next_prev_cancel: got idx=%0d pulses=%0d expected idx=4 pulses=0", op_index, upd);
        end
        operands_in = 10'h15A;
        press_btn(3'b101, 12, upd);
        n_checks++; if (op_index !== 3'd5 || operands_out !== 10'h15A || upd != 1) begin
            n_fail++; $display("FAIL load_with_next: got idx=%0d op=%h pulses=%0d expected idx=5 op=15a pulses=1",
                               op_index, operands_out, upd);
        end
        n_checks++; if (sw_sel !== 6'b010000) begin n_fail++; $display("FAIL load_with_next_sel: got %b expected 010000", sw_sel); end
    endtask

    task automatic test_reset_held();
        int upd;
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++; if (op_index !== 3'd0 || sw_sel !== 6'd0 || operands_out !== 10'd0 || update !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got idx=%0d sel=%b op=%h upd=%b expected all zero",
                               op_index, sw_sel, operands_out, update);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        upd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (update === 1'b1 || op_index !== 3'd0) upd++;
        end
        n_checks++; if (upd != 0) begin
            n_fail++; $display("FAIL held_through_reset: got %0d bad cycles expected 0", upd);
        end
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        btn_next = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_checks++; if (op_index !== ((i >= 7) ? 3'd1 : 3'd0)) begin
                n_fail++; $display("FAIL repress_idx edge %0d: got %0d expected %0d", i, op_index, (i >= 7) ? 1 : 0);
            end
        end
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_next_latency();
        test_prev_wrap();
        test_bounce();
        test_auto_scan();
        test_load();
        test_reset_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mode_controller.md
Name: alu_mode_controller

Overview:
- Sequences the 7-operation ALU display datapath and replaces the six raw operation-select switches.
- Debounces the next/prev push-buttons, keeps the current operation index (0..6), and can auto-scan through all operations at a fixed period.
- Latches the 10-bit operand word on request and drives the ALU's one-hot select lines and operand bus from registers.
- Sits between the board I/O and the ALU top level.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed before a button level is accepted (minimum 2).
- SCAN_CYCLES, 50000000: auto-scan dwell time per operation, in cycles (minimum 2).
- NUM_OPS, 7: number of operations; index range is 0..NUM_OPS-1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- btn_next  in  1  raw, asynchronous button; advance the operation.
- btn_prev  in  1  raw, asynchronous button; step the operation back.
- auto_en  in  1  level; 1 enables auto-scan (2-flop synchronized).
- load  in  1  raw button; capture operands_in (synchronized and debounced like the other buttons).
- operands_in  in  10  switch operand word.
- operands_out  out  10  latched operand word to the ALU.
- sw_sel  out  6  one-hot select to the ALU: bit k-1 is set for index k; all zero for index 0.
- op_index  out  3  current operation index.
- update  out  1  one-cycle pulse whenever op_index or operands_out changes.

Behaviour:
- Reset (asynchronous, resetn=0):
  - op_index=0, sw_sel=6'b0, operands_out=10'b0, update=0.
  - All synchronizer, debounce and scan counters are cleared; accepted button levels are 0.
- Input conditioning:
  - Each of btn_next, btn_prev and load passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer: the counter increments while the synced value differs from the accepted level, and clears when they are equal.
  - The accepted level flips on the cycle the counter reaches DEBOUNCE_CYCLES-1.
  - A rising edge of the accepted level produces a one-cycle press pulse on the next cycle.
- Latency:
  - A raw press held stable changes op_index exactly DEBOUNCE_CYCLES+3 clock edges after the raw edge (2 sync + DEBOUNCE_CYCLES + 1 register).
  - sw_sel and update change on the same edge as op_index.
- Index update, priority per cycle:
  1. next_pulse and prev_pulse in the same cycle: no change, no update.
  2. next_pulse alone: index+1; NUM_OPS-1 wraps to 0.
  3. prev_pulse alone: index-1; 0 wraps to NUM_OPS-1.
  4. Otherwise, if auto_en_sync=1 and the scan counter equals SCAN_CYCLES-1: index+1 with wrap.
- Scan counter:
  - Counts only while auto_en_sync=1.
  - Clears when auto_en_sync=0, on terminal count, and on any manual next/prev pulse, so a manual step restarts the full dwell.
- Operand latch:
  - On load_pulse, operands_out <= operands_in, sampled on the pulse cycle.
  - If the value is identical, update still pulses.
  - A load coinciding with an index change produces a single update pulse.
- Output encoding:
  - sw_sel is registered and derived from the next index value, never decoded combinationally from op_index.
  - It is always zero- or one-hot, so ALU priority never resolves between multiple bits.
- Reset mid-operation: pending debounce counts and scan progress are discarded; there is no spurious press after reset release, even with a button held through reset.
- Buttons held indefinitely: exactly one step per press; no auto-repeat.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - NUM_OPS.
  - The op_index width constant.
  - An index-to-one-hot function used for sw_sel.
- One sub-module is natural: btn_debounce (synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES).
- It is instantiated three times, for next, prev and load.

Test Plan:
Run with DEBOUNCE_CYCLES=4 and SCAN_CYCLES=10.
1. Reset, then hold btn_next high for 20 cycles -> op_index goes 0→1 exactly 7 edges after the raw edge; sw_sel=6'b000001; one update pulse; no further steps while held.
2. Press prev from index 0 -> op_index=6, sw_sel=6'b100000. Then press next -> op_index=0, sw_sel=0.
3. Bounce btn_next: toggle every 2 cycles for 12 cycles, then hold low -> no index change and no update.
4. auto_en=1 for 75 cycles from index 0 -> index sequence 1,2,…,6,0 at 10-cycle intervals; a manual next at mid-dwell advances the index immediately and the following auto step comes 10 cycles later.
5. operands_in=10'h2A5 with a load press -> operands_out=10'h2A5 on the same edge as the update pulse. Coincident next and prev pulses -> op_index unchanged.
6. Assert resetn low mid-debounce with btn_next held, release with the button still held -> all outputs 0 during reset; no index change until the button is released and pressed again.
